fe_queue_stage: RTL

//  Parametrised fetch stage with its own PC register, a DEPTH-entry instruction queue and redirect/flush support.

---
 rtl/fe_queue_stage_pkg.sv | 52 +++++
 rtl/fe_queue_stage_fifo.sv | 65 ++++++
 rtl/fe_queue_stage.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fe_queue_stage_pkg.sv
// Shared types for the fetch queue stage: address/instruction types, the
// memory read request/response structs, the decode handoff record and the
// fetch FSM states. No logic; imported by every other file of the block.
package fe_queue_stage_pkg;

    localparam int ADDR_W     = 32;
    localparam int INST_WIDTH = 32;
    localparam int BYTE_WIDTH = 8;
    localparam int INST_BYTES = INST_WIDTH / BYTE_WIDTH;

    typedef logic [ADDR_W-1:0]     addr_t;
    typedef logic [INST_WIDTH-1:0] inst_t;
    typedef logic [INST_BYTES-1:0] mask_t;

    // Decode handoff record; also the queue entry format.
    typedef struct packed {
        logic  valid;
        addr_t pc;
        inst_t inst;
    } if_id_t;

    typedef if_id_t fe_entry_t;

    localparam if_id_t IF_ID_RST = '0;

    typedef struct packed {
        addr_t addr;
        mask_t mask;
        logic  en;
    } mem_read_req_t;

    typedef struct packed {
        logic  done;
        logic  valid;
        inst_t data;
    } mem_read_rsp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } fe_state_e;

    localparam addr_t ADDR_STEP = addr_t'(INST_BYTES);

    // Fetch addresses are always instruction aligned.
    function automatic addr_t align_pc(input addr_t a);
        return a & ~addr_t'(INST_BYTES - 1);
    endfunction

endpackage

// File: rtl/fe_queue_stage_fifo.sv
// Purpose: DEPTH-entry circular instruction queue (fe_inst_fifo), wrap by extra pointer bit, sync flush.
// Latency: push visible at head the cycle after the write edge; no bypass.
// Backpressure: none internally; caller guarantees push only when a slot is free or a pop
//   happens in the same cycle. Ports: push/push_dat in, pop in, flush in (beats push/pop),
//   head_vld/head_dat out (IF_ID_RST when empty), count out.
module fe_inst_fifo
    import fe_queue_stage_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  fe_entry_t              push_dat,
    input  logic                   pop,
    input  logic                   flush,
    output logic                   head_vld,
    output fe_entry_t              head_dat,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    fe_entry_t   mem_q [DEPTH];
    fe_entry_t   mem_d [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            // At full with a simultaneous pop the write lands on the slot
            // being retired this same edge, so nothing live is overwritten.
            if (push) begin
                mem_d[wr_ptr_q[AW-1:0]] = push_dat;
                wr_ptr_d                = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
        mem_q <= mem_d;
    end

    assign count    = wr_ptr_q - rd_ptr_q;
    assign head_vld = (count != '0);
    assign head_dat = head_vld ? mem_q[rd_ptr_q[AW-1:0]] : IF_ID_RST;

endmodule

// File: rtl/fe_queue_stage.sv
// Purpose: fetch stage with PC, one-outstanding memory read, DEPTH-entry queue, redirect/flush, fault halt.
// Latency: rsp.done in cycle N -> if_id.valid in cycle N+1; next request may issue the cycle after done.
// Backpressure: slot reserved at issue (rdy = count+inflight < DEPTH); decode pops on next_rdy && valid.
// Ports: clk/rst (sync, active-high), en, redirect/redirect_pc, inst_read_req/inst_read_rsp,
//   next_rdy/if_id, rdy, fault/fault_pc. Optional FE_QUEUE_PERF_CNT_EN adds CNT_W and the
//   stall_cnt/drop_cnt saturating counters.
module fe_queue_stage
    import fe_queue_stage_pkg::*;
#(
    parameter int    DEPTH    = 4,
    parameter addr_t RESET_PC = 32'h0000_0000
`ifdef FE_QUEUE_PERF_CNT_EN
    ,
    parameter int    CNT_W    = 32
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          redirect,
    input  addr_t         redirect_pc,
    input  mem_read_rsp_t inst_read_rsp,
    output mem_read_req_t inst_read_req,
    input  logic          next_rdy,
    output if_id_t        if_id,
    output logic          rdy,
    output logic          fault,
    output addr_t         fault_pc
`ifdef FE_QUEUE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] drop_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [CW:0] ONE_W   = (CW+1)'(1);

    fe_state_e     state_q, state_d;
    addr_t         pc_q, pc_d;
    addr_t         drain_pc_q, drain_pc_d;
    addr_t         fault_pc_q, fault_pc_d;
    logic          fault_q, fault_d;

    logic [CW-1:0] count;
    logic          head_vld;
    if_id_t        head_dat;
    logic          inflight;
    logic          rsp_done;
    logic          pop_fire;
    logic          push;
    fe_entry_t     push_dat;
    logic [CW:0]   occ;
    logic [CW:0]   occ_after;

    assign rsp_done = inst_read_rsp.done;
    // DRAIN still owns the memory port, so it counts as a reserved slot.
    assign inflight = (state_q == FETCH) || (state_q == DRAIN);
    assign pop_fire = next_rdy && head_vld && !redirect;
    assign push     = (state_q == FETCH) && rsp_done && inst_read_rsp.valid && !redirect;
    assign push_dat = '{valid: 1'b1, pc: pc_q, inst: inst_read_rsp.data};

    assign occ       = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign rdy       = (occ < DEPTH_W);
    // Occupancy once this cycle's push and pop have landed.
    assign occ_after = {1'b0, count} + ONE_W - {{CW{1'b0}}, pop_fire};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drain_pc_d = drain_pc_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        if (redirect) begin
            pc_d    = align_pc(redirect_pc);
            fault_d = 1'b0;
            if (inflight && !rsp_done) begin
                // The old request must complete on the bus; keep its address
                // driven until done while the new PC waits in pc_q.
                state_d = DRAIN;
                if (state_q == FETCH) begin
                    drain_pc_d = pc_q;
                end
            end else begin
                state_d = IDLE;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (en && rdy) begin
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    if (rsp_done) begin
                        if (inst_read_rsp.valid) begin
                            pc_d    = pc_q + ADDR_STEP;
                            state_d = (en && (occ_after < DEPTH_W)) ? FETCH : IDLE;
                        end else begin
                            fault_d    = 1'b1;
                            fault_pc_d = pc_q;
                            state_d    = HALT;
                        end
                    end
                end
                DRAIN: begin
                    if (rsp_done) begin
                        state_d = IDLE;
                    end
                end
                HALT: begin
                    state_d = HALT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            drain_pc_q <= RESET_PC;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drain_pc_q <= drain_pc_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    always_comb begin
        inst_read_req      = '0;
        inst_read_req.addr = (state_q == DRAIN) ? drain_pc_q : pc_q;
        inst_read_req.mask = '1;
        inst_read_req.en   = inflight;
    end

    fe_inst_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop_fire),
        .flush    (redirect),
        .head_vld (head_vld),
        .head_dat (head_dat),
        .count    (count)
    );

    assign if_id    = head_dat;
    assign fault    = fault_q;
    assign fault_pc = fault_pc_q;

`ifdef FE_QUEUE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             rsp_dropped;
    logic [CW:0]      drop_inc;
    logic [CNT_W:0]   drop_sum;

    // A response is thrown away when redirect hits its done cycle or when
    // it finishes during DRAIN; flushed entries are all valid by construction.
    assign rsp_dropped = rsp_done && ((redirect && inflight) || (state_q == DRAIN));
    assign drop_inc    = (redirect ? {1'b0, count} : '0) + {{CW{1'b0}}, rsp_dropped};
    assign drop_sum    = {1'b0, drop_cnt_q} + (CNT_W+1)'(drop_inc);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (en && !rdy && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`endif

endmodule
